// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-stage controller for the pipelined CPU. It owns the architectural
// fetch PC and keeps at most one instruction-memory request outstanding. It
// applies EX-stage redirects, generates the IF/ID and ID/EX flushes, and
// honours hazard-unit stalls. Responses go to IF/ID through a one-entry skid
// buffer, so a response that arrives during a stall is never lost.
//
// Optional build macro: FETCH_PERF_CNT_EN adds three saturating performance
// counters (redirects, stall cycles, drain cycles) as extra outputs.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall_i           hazard unit: hold IF/ID, issue no new fetch
//   ex_pcsrc          EX stage: redirect taken this cycle
//   ex_pc_next        EX stage: redirect target
//   imem_req/addr     fetch request and its address
//   imem_ack/rdata    response valid (may share a cycle with the request), data
//   ifid_valid/pc/pc_plus4/instr   IF/ID pipeline register
//   flush_ifid/idex   combinational stage kills, asserted with a redirect
//   misalign_err      sticky flag: a redirect target was not word aligned
//   perf_*            (FETCH_PERF_CNT_EN only) saturating event counters
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ex_pcsrc,
  input  logic [31:0] ex_pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_redirects,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_drain_cycles
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;

  // A zero-width counter cannot hold a count; reject it at elaboration.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fetch_sequencer: CNT_W must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;   // address of the request being drained
  logic        outstanding_q;  // FETCH request raised, not yet acked
  logic        misalign_q;

  logic        skid_valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;

  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc_plus4_q;
  logic [31:0] ifid_instr_q;

  logic redirect;      // redirect accepted this cycle
  logic misaligned;    // redirect target not word aligned
  logic ack;           // handshake completes this cycle
  logic fetch_ack;     // completed response that must be kept
  logic drain_start;   // redirect while a request is still in flight

  // -------------------------------------------------------------------------
  // Request generation and next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    state_d     = state_q;

    // After a misaligned redirect the fetch unit is dead until reset, so
    // later redirects (including any while draining towards HALT) are ignored.
    redirect    = ex_pcsrc && (state_q != HALT) && !misalign_q;
    misaligned  = (ex_pc_next[1:0] != 2'b00);

    unique case (state_q)
      // A new fetch needs an empty skid so its response always has a home;
      // an outstanding request stays up regardless of stall or redirect.
      FETCH:   imem_req = outstanding_q || (!stall_i && !skid_valid_q && !redirect);
      DRAIN:   begin
                 imem_req  = 1'b1;
                 imem_addr = drain_addr_q;
               end
      default: imem_req = 1'b0;
    endcase

    ack         = imem_req && imem_ack;
    fetch_ack   = ack && (state_q == FETCH) && !redirect;
    drain_start = redirect && imem_req && !imem_ack;

    if (redirect) begin
      if (drain_start)     state_d = DRAIN;
      else if (misaligned) state_d = HALT;
      else                 state_d = FETCH;
    end else begin
      unique case (state_q)
        BOOT:    state_d = FETCH;
        DRAIN:   if (ack) state_d = misalign_q ? HALT : FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  assign flush_ifid = redirect;
  assign flush_idex = redirect;

  // -------------------------------------------------------------------------
  // Control state and program counter
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      drain_addr_q  <= RESET_VECTOR;
      outstanding_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= (state_q == FETCH) && imem_req && !imem_ack && !redirect;
      if (redirect)        pc_q <= ex_pc_next;
      else if (fetch_ack)  pc_q <= pc_q + 32'd4;
      if (drain_start)     drain_addr_q <= imem_addr;
      if (redirect && misaligned) misalign_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Skid buffer and IF/ID register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q    <= 1'b0;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_instr_q    <= 32'd0;
    end else if (redirect || (state_q == HALT)) begin
      skid_valid_q <= 1'b0;
      ifid_valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (skid_valid_q) begin
        // Older skid entry advances; a response this cycle refills the skid.
        ifid_valid_q    <= 1'b1;
        ifid_pc_q       <= skid_pc_q;
        ifid_pc_plus4_q <= skid_pc_q + 32'd4;
        ifid_instr_q    <= skid_instr_q;
        skid_valid_q    <= fetch_ack;
      end else if (fetch_ack) begin
        ifid_valid_q    <= 1'b1;
        ifid_pc_q       <= pc_q;
        ifid_pc_plus4_q <= pc_q + 32'd4;
        ifid_instr_q    <= imem_rdata;
      end else begin
        ifid_valid_q <= 1'b0;
      end
    end else if (fetch_ack) begin
      skid_valid_q <= 1'b1;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read while
  // skid_valid_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (fetch_ack && (stall_i || skid_valid_q)) begin
      skid_pc_q    <= pc_q;
      skid_instr_q <= imem_rdata;
    end
  end

  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_instr    = ifid_instr_q;
  assign misalign_err  = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
      perf_drain_cycles <= '0;
    end else begin
      if (ex_pcsrc) perf_redirects <= sat_inc(perf_redirects);
      if (stall_i && (state_q != BOOT) && (state_q != HALT))
        perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (state_q == DRAIN) perf_drain_cycles <= sat_inc(perf_drain_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A memory responder with a
// programmable latency answers requests. A transaction-level model (expected
// fetch PC, in-flight request, FIFO of fetched-but-undelivered instructions,
// IF/ID contents) predicts every output, and a compare process checks the DUT
// against it on each falling edge. Directed scenarios add literal expectations
// for reset, start-up, stall, redirect, drain, misalignment and PC wrap.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        ex_pcsrc = 1'b0;
  logic [31:0] ex_pc_next = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        flush_ifid;
  logic        flush_idex;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .ex_pcsrc     (ex_pcsrc),
    .ex_pc_next   (ex_pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr   (ifid_instr),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .misalign_err (misalign_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // ---------------- memory responder ----------------
  int mem_lat = 0;   // cycles a request waits before ack (0 = same cycle)
  int mem_cnt;

  always_comb begin
    imem_ack   = imem_req && (mem_cnt >= mem_lat);
    imem_rdata = imem_ack ? instr_of(imem_addr) : 32'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    mem_cnt <= 0;
    else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else                           mem_cnt <= 0;
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_boot, m_halt, m_mis, m_out, m_discard, m_valid;
  logic [31:0] m_pc, m_out_addr, m_ifid_pc;
  logic [31:0] m_q[$];   // fetched instructions not yet in IF/ID

  function automatic bit m_redirect();
    return ex_pcsrc && !m_halt && !m_mis;
  endfunction

  function automatic bit m_req();
    if (m_boot || m_halt) return 1'b0;
    return m_out || (!stall_i && (m_q.size() == 0) && !m_redirect());
  endfunction

  function automatic logic [31:0] m_addr();
    return m_out ? m_out_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_out = 1'b0;
    m_discard = 1'b0; m_valid = 1'b0; m_pc = 32'h0; m_out_addr = 32'h0;
    m_ifid_pc = 32'h0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit          red, iss, ackd;
    logic [31:0] a;
    red  = m_redirect();
    iss  = m_req();
    a    = m_addr();
    ackd = imem_ack && iss;
    m_boot = 1'b0;
    if (red) begin
      m_valid = 1'b0;
      m_q.delete();
      m_pc = ex_pc_next;
      if (ex_pc_next[1:0] != 2'b00) m_mis = 1'b1;
      m_out     = iss && !ackd;
      m_discard = m_out;
      if (m_out) m_out_addr = a;
      else if (m_mis) m_halt = 1'b1;
    end else begin
      if (ackd) begin
        m_out = 1'b0;
        if (m_discard) begin
          m_discard = 1'b0;
          if (m_mis) m_halt = 1'b1;
        end else begin
          m_q.push_back(a);
          m_pc = a + 32'd4;
        end
      end else if (iss) begin
        m_out = 1'b1;
        m_out_addr = a;
      end
      if (!stall_i) begin
        if (m_q.size() > 0) begin
          m_ifid_pc = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    if (m_halt) begin
      m_valid = 1'b0;
      m_q.delete();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk);
    check1("m_flush_ifid", flush_ifid, m_redirect());
    check1("m_flush_idex", flush_idex, m_redirect());
    check1("m_imem_req", imem_req, m_req());
    if (m_req()) check("m_imem_addr", imem_addr, m_addr());
    check1("m_misalign", misalign_err, m_mis);
    check1("m_ifid_valid", ifid_valid, m_valid);
    if (m_valid) begin
      check("m_ifid_pc", ifid_pc, m_ifid_pc);
      check("m_ifid_pc_plus4", ifid_pc_plus4, m_ifid_pc + 32'd4);
      check("m_ifid_instr", ifid_instr, instr_of(m_ifid_pc));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge of the first cycle requesting address a.
  task automatic wait_req(input logic [31:0] a, input bit no_ack);
    int n = 0;
    @(negedge clk);
    while (!(imem_req && imem_addr == a && !(no_ack && imem_ack)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check1($sformatf("reach_req_%h", a), imem_req && (imem_addr == a), 1'b1);
  endtask

  task automatic wait_ifid(input logic [31:0] pc);
    int n = 0;
    @(negedge clk);
    while (!(ifid_valid && ifid_pc == pc) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check1($sformatf("reach_ifid_%h", pc), ifid_valid && (ifid_pc == pc), 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check1("rst_ifid_valid", ifid_valid, 1'b0);
    check("rst_ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    check1("rst_flush", flush_ifid, 1'b0);
    check1("rst_misalign", misalign_err, 1'b0);

    // Start-up with zero-wait memory
    next_cycle(); rst_n = 1'b1;                       // cycle 1: BOOT
    @(negedge clk); check1("c1_no_req", imem_req, 1'b0);
    @(negedge clk); check1("c2_req", imem_req, 1'b1);
                    check("c2_addr", imem_addr, 32'h0);
    @(negedge clk); check1("c3_valid", ifid_valid, 1'b1);
                    check("c3_ifid_pc", ifid_pc, 32'h0);
                    check("c3_pc_plus4", ifid_pc_plus4, 32'h4);
                    check("c3_addr", imem_addr, 32'h4);
    @(negedge clk); check("c4_addr", imem_addr, 32'h8);

    // Stall for 3 cycles while the response for 0x10 arrives
    next_cycle(); mem_lat = 1;
    wait_req(32'h10, 1'b1);
    check("stall_pre_ifid_pc", ifid_pc, 32'hC);
    next_cycle(); stall_i = 1'b1;
    @(negedge clk); check1("stall_req_held", imem_req, 1'b1);
                    check("stall_addr_held", imem_addr, 32'h10);
    next_cycle();
    @(negedge clk); check1("stall_no_req", imem_req, 1'b0);
                    check("stall_ifid_hold", ifid_pc, 32'hC);
    next_cycle();
    @(negedge clk); check1("stall_no_req2", imem_req, 1'b0);
    next_cycle(); stall_i = 1'b0;
    @(negedge clk); check1("skid_full_no_req", imem_req, 1'b0);
    @(negedge clk); check("skid_to_ifid", ifid_pc, 32'h10);
                    check("resume_addr", imem_addr, 32'h14);

    // Redirect to 0x200 while the response for 0x40 arrives
    wait_req(32'h40, 1'b1);
    next_cycle(); ex_pcsrc = 1'b1; ex_pc_next = 32'h200;
    @(negedge clk); check1("redir_flush_ifid", flush_ifid, 1'b1);
                    check1("redir_flush_idex", flush_idex, 1'b1);
                    check1("redir_ack_same_cycle", imem_ack, 1'b1);
    next_cycle(); ex_pcsrc = 1'b0;
    @(negedge clk); check1("redir_bubble", ifid_valid, 1'b0);
                    check("redir_target", imem_addr, 32'h200);

    // 3-cycle memory: redirect to 0x80 one cycle after requesting 0x20
    next_cycle(); mem_lat = 3; ex_pcsrc = 1'b1; ex_pc_next = 32'h20;
    next_cycle(); ex_pcsrc = 1'b0;
    wait_req(32'h20, 1'b1);
    next_cycle(); ex_pcsrc = 1'b1; ex_pc_next = 32'h80;
    @(negedge clk); check1("drain_flush", flush_ifid, 1'b1);
    next_cycle(); ex_pcsrc = 1'b0;
    @(negedge clk); check("drain_addr1", imem_addr, 32'h20);
    @(negedge clk); check("drain_addr2", imem_addr, 32'h20);
                    check1("drain_ack", imem_ack, 1'b1);
    @(negedge clk); check("after_drain_addr", imem_addr, 32'h80);
                    check1("after_drain_valid", ifid_valid, 1'b0);

    // PC wrap at the top of the address space
    next_cycle(); mem_lat = 0; ex_pcsrc = 1'b1; ex_pc_next = 32'hFFFF_FFF8;
    next_cycle(); ex_pcsrc = 1'b0;
    wait_ifid(32'hFFFF_FFFC);
    check("wrap_pc_plus4", ifid_pc_plus4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Misaligned redirect, then HALT until reset
    next_cycle(); ex_pcsrc = 1'b1; ex_pc_next = 32'h102;
    @(negedge clk); check1("mis_flush", flush_ifid, 1'b1);
    next_cycle(); ex_pcsrc = 1'b0;
    @(negedge clk); check1("mis_err", misalign_err, 1'b1);
                    check1("halt_no_req", imem_req, 1'b0);
    next_cycle(); ex_pcsrc = 1'b1; ex_pc_next = 32'h300;
    @(negedge clk); check1("halt_ignores_redirect", flush_ifid, 1'b0);
    next_cycle(); ex_pcsrc = 1'b0;
    repeat (2) @(negedge clk);
    check1("halt_still_no_req", imem_req, 1'b0);
    check1("halt_err_sticky", misalign_err, 1'b1);

    // Asynchronous reset in the middle of HALT
    next_cycle(); rst_n = 1'b0;
    #1;
    check1("hrst_misalign", misalign_err, 1'b0);
    check1("hrst_req", imem_req, 1'b0);
    check("hrst_addr", imem_addr, 32'h0);
    check1("hrst_valid", ifid_valid, 1'b0);
    next_cycle(); rst_n = 1'b1;
    @(negedge clk); check1("hrst_c1_no_req", imem_req, 1'b0);
    @(negedge clk); check1("hrst_c2_req", imem_req, 1'b1);
                    check("hrst_c2_addr", imem_addr, 32'h0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-stage controller for the pipelined CPU.
- Owns the architectural fetch PC and sequences single-outstanding instruction-memory requests.
- Applies EX-stage redirects (branch/JAL/JALR PCsrc + target), generates IF/ID and ID/EX flushes, and honours hazard-unit stalls.
- Drives the IF/ID register through a one-entry skid buffer so memory responses arriving during a stall are never lost.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard unit: hold IF/ID contents, issue no new fetch.
- ex_pcsrc  input  1  EX stage: redirect taken this cycle.
- ex_pc_next  input  32  EX stage: redirect target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address.
- imem_ack  input  1  response valid; may be asserted in the same cycle as imem_req.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- ifid_valid  output  1  IF/ID holds a live instruction.
- ifid_pc  output  32  PC of the IF/ID instruction.
- ifid_pc_plus4  output  32  ifid_pc + 4, mod 2^32.
- ifid_instr  output  32  instruction word.
- flush_ifid  output  1  kill the IF/ID stage (combinational).
- flush_idex  output  1  kill the ID/EX stage (combinational).
- misalign_err  output  1  sticky: redirect target not word aligned.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc_q=RESET_VECTOR, state=BOOT, skid empty.
  - All outputs 0, except imem_addr=RESET_VECTOR.
- States: BOOT, FETCH, DRAIN, HALT.
- BOOT:
  - Lasts one cycle with imem_req=0, then goes to FETCH.
  - First request is therefore issued in the 2nd cycle after rst_n rises.
- FETCH:
  - imem_req=1 when no stall, skid empty and no redirect; imem_addr=pc_q.
  - Once raised, imem_req stays 1 with imem_addr stable until imem_ack (outstanding), regardless of stall_i.
  - On ack: pc_q<=pc_q+4 (mod 2^32 wrap).
  - Zero-wait memory sustains one fetch per cycle.
- Response routing on ack without redirect:
  - stall_i=0 and skid empty: load IF/ID {pc, instr}, ifid_valid<=1.
  - stall_i=1: capture into skid; IF/ID holds.
- IF/ID update when stall_i=0:
  - Skid full: skid moves to IF/ID, skid empties. Any ack that cycle goes to the skid, which only occurs if a request was outstanding.
  - Skid empty and no ack: ifid_valid<=0 (bubble).
- stall_i=1: IF/ID registers and ifid_valid hold.
- Redirect (ex_pcsrc=1):
  - Priority over stall.
  - flush_ifid=flush_idex=1 combinationally in the same cycle.
  - Next edge: ifid_valid<=0, skid cleared, pc_q<=ex_pc_next.
  - Ack in the same cycle: its data is discarded; stay in FETCH.
  - Request outstanding without ack: go to DRAIN.
  - Nothing outstanding: FETCH of the target starts next cycle.
- DRAIN:
  - imem_req held with the old address until ack; data discarded.
  - Then FETCH at the redirected pc_q.
  - A further redirect in DRAIN overwrites pc_q and flushes again.
- Misaligned redirect (ex_pc_next[1:0]!=0):
  - Flushes still asserted.
  - misalign_err<=1 (sticky); go to HALT, draining any outstanding request first.
  - HALT: imem_req=0, ifid_valid=0, redirects ignored; exit only by reset.
- Reset mid-request: request abandoned immediately; no response is expected after reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_redirects[CNT_W-1:0] (counts ex_pcsrc cycles), perf_stall_cycles[CNT_W-1:0] (counts stall_i cycles outside BOOT/HALT) and perf_drain_cycles[CNT_W-1:0] (cycles in DRAIN).
  - Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset release with zero-wait memory (ack = req):
  - imem_req first high in cycle 2, addresses 0x0, 0x4, 0x8 in consecutive cycles.
  - ifid_valid high from cycle 3 with ifid_pc=0x0, ifid_pc_plus4=0x4.
- stall_i high for 3 cycles while ack arrives for 0x10:
  - IF/ID holds 0x0C; 0x10 goes to the skid; imem_req low after ack.
  - On release, ifid_pc=0x10 next edge, then fetch 0x14 resumes; no instruction lost or duplicated.
- Redirect to 0x200 with ack in the same cycle for 0x40:
  - flush_ifid/flush_idex=1 that cycle; 0x40 discarded; next imem_addr=0x200; ifid_valid=0 for one cycle.
- Memory with 3-cycle latency, redirect to 0x80 one cycle after request 0x20:
  - DRAIN keeps imem_addr=0x20 until ack; data dropped; next request 0x80.
- Redirect to 0x102:
  - misalign_err=1, imem_req stays 0, later ex_pcsrc ignored.
  - Asserting rst_n=0 mid-HALT clears all state.
- Fetch at pc=0xFFFF_FFFC: next address wraps to 0x0000_0000, and ifid_pc_plus4=0x0.
